ysyx_22051468_exu_out_stage: RTL and testbench

Execute-stage output buffer that consumes the ALU result and flags and hands a finished execute record to the MEM stage. Per instruction it:
- applies RV64 W-type sign extension;
- resolves conditional branches from the ALU `zero`/`slt_out` flags and computes the branch target;
- holds the record in a 2-entry skid buffer with a valid/ready handshake on both sides.

Upstream is the decode/ALU pair; downstream is the MEM stage.

---
 rtl/ysyx_22051468_exu_out_stage.sv | 131 +++++++++++++
 tb/tb_ysyx_22051468_exu_out_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22051468_exu_out_stage.sv
// Execute-stage output buffer: W-type sign extension, branch resolution, 2-entry skid buffer to MEM.
// Latency 1 cycle; in_ready depends only on the state register (low when both entries are full).
module ysyx_22051468_exu_out_stage #(
    parameter int WIDTH          = 64,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          alu_result_i,
    input  logic                      alu_zero_i,
    input  logic                      alu_slt_i,
    input  logic                      is_W_i,
    input  logic [2:0]                br_type_i,
    input  logic [WIDTH-1:0]          pc_i,
    input  logic [WIDTH-1:0]          imm_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                      rd_wen_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_result,
    output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
    output logic                      out_rd_wen,
    output logic                      out_br_taken,
    output logic [WIDTH-1:0]          out_br_target
);

    typedef struct packed {
        logic [WIDTH-1:0]          result;
        logic [WIDTH-1:0]          br_target;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      rd_wen;
        logic                      br_taken;
    } rec_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, state_n;
    rec_t   head, skid, new_rec;
    logic   accept, pop, is_branch, taken;
    logic   load_head_new, load_head_skid, load_skid;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        case (br_type_i)
            3'd1: begin is_branch = 1'b1; taken = alu_zero_i;  end
            3'd2: begin is_branch = 1'b1; taken = ~alu_zero_i; end
            3'd3: begin is_branch = 1'b1; taken = alu_slt_i;   end
            3'd4: begin is_branch = 1'b1; taken = ~alu_slt_i;  end
            default: ;
        endcase
    end

    always_comb begin
        new_rec           = '0;
        new_rec.result    = is_W_i ? {{(WIDTH-32){alu_result_i[31]}}, alu_result_i[31:0]}
                                   : alu_result_i;
        new_rec.br_target = pc_i + imm_i;
        new_rec.rd_addr   = rd_addr_i;
        // Branches never write back, and x0 is hard-wired to zero.
        new_rec.rd_wen    = rd_wen_i & (rd_addr_i != '0) & ~is_branch;
        new_rec.br_taken  = taken;
    end

    always_comb begin
        state_n        = state;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_n       = ONE;
                    load_head_new = 1'b1;
                end
                ONE: begin
                    if (accept && pop) begin
                        load_head_new = 1'b1;
                    end else if (accept) begin
                        state_n   = TWO;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_n = EMPTY;
                    end
                end
                TWO: if (pop) begin
                    state_n        = ONE;
                    load_head_skid = 1'b1;
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head_new)       head <= new_rec;
            else if (load_head_skid) head <= skid;
            if (load_skid)           skid <= new_rec;
        end
    end

    assign out_result    = head.result;
    assign out_rd_addr   = head.rd_addr;
    assign out_rd_wen    = head.rd_wen;
    assign out_br_taken  = head.br_taken;
    assign out_br_target = head.br_target;

endmodule

// File: tb/tb_ysyx_22051468_exu_out_stage.sv
// Bench for the execute output stage: directed scenarios plus random traffic against a queue model.
module tb_ysyx_22051468_exu_out_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] alu_result_i;
    logic        alu_zero_i;
    logic        alu_slt_i;
    logic        is_W_i;
    logic [2:0]  br_type_i;
    logic [63:0] pc_i;
    logic [63:0] imm_i;
    logic [4:0]  rd_addr_i;
    logic        rd_wen_i;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd_addr;
    logic        out_rd_wen;
    logic        out_br_taken;
    logic [63:0] out_br_target;

    always #5 clk = ~clk;

    ysyx_22051468_exu_out_stage #(.WIDTH(64), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i), .alu_slt_i(alu_slt_i),
        .is_W_i(is_W_i), .br_type_i(br_type_i), .pc_i(pc_i), .imm_i(imm_i),
        .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd_addr(out_rd_addr), .out_rd_wen(out_rd_wen),
        .out_br_taken(out_br_taken), .out_br_target(out_br_target)
    );

    typedef struct packed {
        logic [63:0] result;
        logic [63:0] target;
        logic [4:0]  rd;
        logic        wen;
        logic        taken;
    } mrec_t;

    mrec_t q[$];
    int checks = 0;
    int errors = 0;

    // Expected record straight from the instruction-level rules.
    function automatic mrec_t model_rec();
        mrec_t r;
        bit    br;
        br       = (br_type_i >= 3'd1) && (br_type_i <= 3'd4);
        r.result = is_W_i ? 64'($signed(alu_result_i[31:0])) : alu_result_i;
        r.target = pc_i + imm_i;
        r.rd     = rd_addr_i;
        r.wen    = rd_wen_i && (rd_addr_i != 5'd0) && !br;
        case (br_type_i)
            3'd1:    r.taken = alu_zero_i;
            3'd2:    r.taken = !alu_zero_i;
            3'd3:    r.taken = alu_slt_i;
            3'd4:    r.taken = !alu_slt_i;
            default: r.taken = 1'b0;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("q_result", out_result, q[0].result);
            chk("q_target", out_br_target, q[0].target);
            chk("q_rd", 64'(out_rd_addr), 64'(q[0].rd));
            chk("q_wen", 64'(out_rd_wen), 64'(q[0].wen));
            chk("q_taken", 64'(out_br_taken), 64'(q[0].taken));
        end
    endtask

    // One clock: advance the model on the same edge as the DUT, then compare.
    task automatic cycle();
        bit    acc, pp;
        mrec_t cur;
        acc = in_valid && (q.size() < 2);
        pp  = out_ready && (q.size() != 0);
        cur = model_rec();
        @(posedge clk);
        #1;
        if (flush) q.delete();
        else begin
            if (pp)  void'(q.pop_front());
            if (acc) q.push_back(cur);
        end
        check_all();
    endtask

    task automatic set_rec(input logic [63:0] alu, input logic w, input logic [2:0] br,
                           input logic [4:0] rd, input logic wen);
        alu_result_i = alu;
        is_W_i       = w;
        br_type_i    = br;
        rd_addr_i    = rd;
        rd_wen_i     = wen;
    endtask

    logic [3:0] tk_tab, z_tab, s_tab;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_zero_i = 1'b0; alu_slt_i = 1'b0; pc_i = '0; imm_i = '0;
        set_rec(64'd0, 1'b0, 3'd0, 5'd0, 1'b0);
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_target", out_br_target, 64'd0);
        chk("rst_rd", 64'(out_rd_addr), 64'd0);
        chk("rst_wen", 64'(out_rd_wen), 64'd0);
        chk("rst_taken", 64'(out_br_taken), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // W-type sign extension
        out_ready = 1'b1; in_valid = 1'b1;
        set_rec(64'h0000_0000_8000_0001, 1'b1, 3'd0, 5'd5, 1'b1);
        cycle();
        chk("w_result", out_result, 64'hFFFF_FFFF_8000_0001);
        chk("w_wen", 64'(out_rd_wen), 64'd1);
        is_W_i = 1'b0;
        cycle();
        chk("nw_result", out_result, 64'h0000_0000_8000_0001);

        // Branch resolution
        pc_i = 64'h8000_0000; imm_i = 64'hFFFF_FFFF_FFFF_FFF0;
        tk_tab = 4'b0101; z_tab = 4'b0011; s_tab = 4'b1100;
        for (int i = 1; i <= 4; i++) begin
            set_rec(64'h1234, 1'b0, 3'(i), 5'd7, 1'b1);
            alu_zero_i = z_tab[i-1];
            alu_slt_i  = s_tab[i-1];
            cycle();
            chk("br_taken", 64'(out_br_taken), 64'(tk_tab[i-1]));
            chk("br_target", out_br_target, 64'h7FFF_FFF0);
            chk("br_wen", 64'(out_rd_wen), 64'd0);
        end

        // x0 write suppression
        set_rec(64'h55, 1'b0, 3'd0, 5'd0, 1'b1);
        cycle();
        chk("x0_wen", 64'(out_rd_wen), 64'd0);
        in_valid = 1'b0;
        cycle();

        // Backpressure: A, B fill the buffer, C stalls
        out_ready = 1'b0; in_valid = 1'b1;
        set_rec(64'hA, 1'b0, 3'd0, 5'd1, 1'b1); cycle();
        set_rec(64'hB, 1'b0, 3'd0, 5'd2, 1'b1); cycle();
        chk("bp_full", 64'(in_ready), 64'd0);
        set_rec(64'hC, 1'b0, 3'd0, 5'd3, 1'b1); cycle(); cycle();
        chk("bp_stall", 64'(in_ready), 64'd0);
        chk("bp_hold_A", out_result, 64'hA);
        out_ready = 1'b1;
        cycle();
        chk("bp_pop_B", out_result, 64'hB);
        cycle();
        chk("bp_pop_C", out_result, 64'hC);
        in_valid = 1'b0;
        cycle();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Flush priority in the full state
        out_ready = 1'b0; in_valid = 1'b1;
        set_rec(64'hE, 1'b0, 3'd0, 5'd4, 1'b1); cycle();
        set_rec(64'hF, 1'b0, 3'd0, 5'd6, 1'b1); cycle();
        flush = 1'b1; out_ready = 1'b1;
        set_rec(64'h60, 1'b0, 3'd0, 5'd8, 1'b1);
        cycle();
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0;
        cycle(); cycle();
        chk("fl_none", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        set_rec(64'hD, 1'b0, 3'd0, 5'd9, 1'b1);
        cycle();
        chk("fl_D", out_result, 64'hD);
        in_valid = 1'b0;
        cycle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            out_ready    = ($urandom_range(0, 2) != 0);
            flush        = ($urandom_range(0, 24) == 0);
            alu_result_i = {$urandom, $urandom};
            pc_i         = {$urandom, $urandom};
            imm_i        = {$urandom, $urandom};
            alu_zero_i   = 1'($urandom_range(0, 1));
            alu_slt_i    = 1'($urandom_range(0, 1));
            is_W_i       = 1'($urandom_range(0, 1));
            br_type_i    = 3'($urandom_range(0, 7));
            rd_addr_i    = 5'($urandom_range(0, 31));
            rd_wen_i     = 1'($urandom_range(0, 1));
            cycle();
        end
        flush = 1'b0;

        // Asynchronous reset while full
        out_ready = 1'b0; in_valid = 1'b1; pc_i = 64'h100; imm_i = 64'h20;
        set_rec(64'h77, 1'b0, 3'd0, 5'd10, 1'b1); cycle();
        set_rec(64'h88, 1'b0, 3'd0, 5'd11, 1'b1); cycle();
        chk("ar_full", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_ready", 64'(in_ready), 64'd1);
        chk("ar_result", out_result, 64'd0);
        chk("ar_target", out_br_target, 64'd0);
        chk("ar_rd", 64'(out_rd_addr), 64'd0);
        chk("ar_wen", 64'(out_rd_wen), 64'd0);
        q.delete();
        #3 rst_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        set_rec(64'h99, 1'b1, 3'd0, 5'd12, 1'b1);
        cycle();
        in_valid = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
